// File: rtl/if_id_stage.sv
// if_id_stage
//   IF/ID pipeline register sitting directly after the PC/fetch stage.
//   Captures the fetched instruction and PC+4 every cycle, detects load-use
//   hazards against the load currently in ID/EX, squashes on a resolved
//   branch/jump redirect, and keeps saturating stall/flush event counters.
//
// Ports
//   clk, rst       rising-edge clock, synchronous active-high reset
//   order          instruction word from fetch
//   fa_out         PC+4 from fetch
//   redirect       taken branch/jump resolved downstream; squash IF/ID
//   id_ex_memrd    instruction in ID/EX is a load
//   id_ex_rt       destination register of that load
//   id_instr       registered instruction to decode
//   id_pc4         registered PC+4 to decode
//   id_valid       id_instr holds a real instruction (0 = bubble)
//   hazard         load-use stall; holds the fetch PC and this register
//   id_ex_bubble   zero ID/EX control this cycle (hazard & ~redirect)
//   stall_cnt      saturating count of stall cycles
//   flush_cnt      saturating count of redirect (flush) cycles
module if_id_stage #(
   parameter int unsigned        DATA_W = 32,
   parameter int unsigned        CNT_W  = 16,
   parameter logic [DATA_W-1:0]  NOP    = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] order,
   input  logic [DATA_W-1:0] fa_out,
   input  logic              redirect,
   input  logic              id_ex_memrd,
   input  logic [4:0]        id_ex_rt,
   output logic [DATA_W-1:0] id_instr,
   output logic [DATA_W-1:0] id_pc4,
   output logic              id_valid,
   output logic              hazard,
   output logic              id_ex_bubble,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   logic [5:0] op;
   logic [4:0] rs;
   logic [4:0] rt;
   logic       uses_rt;

   // Hazard is derived only from registered state and the ID/EX inputs, so
   // there is no combinational path from order/fa_out back into fetch.
   always_comb begin
      op      = id_instr[31:26];
      rs      = id_instr[25:21];
      rt      = id_instr[20:16];
      uses_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
      hazard  = id_valid && id_ex_memrd && (id_ex_rt != 5'd0) &&
                ((id_ex_rt == rs) || (uses_rt && (id_ex_rt == rt)));
   end

   assign id_ex_bubble = hazard & ~redirect;

   always_ff @(posedge clk) begin
      if (rst) begin
         id_instr  <= NOP;
         id_pc4    <= '0;
         id_valid  <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         // Redirect beats hazard: an older branch kills a stalled younger instruction.
         if (redirect) begin
            id_instr <= NOP;
            id_pc4   <= '0;
            id_valid <= 1'b0;
         end else if (!hazard) begin
            id_instr <= order;
            id_pc4   <= fa_out;
            id_valid <= 1'b1;
         end

         if (id_ex_bubble && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (redirect && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] order = '0;
   logic [31:0] fa_out = '0;
   logic        redirect = 1'b0;
   logic        id_ex_memrd = 1'b0;
   logic [4:0]  id_ex_rt = '0;

   logic [31:0] id_instr, id_pc4;
   logic        id_valid, hazard, id_ex_bubble;
   logic [15:0] stall_cnt, flush_cnt;

   logic [31:0] id_instr4, id_pc44;
   logic        id_valid4, hazard4, id_ex_bubble4;
   logic [3:0]  stall_cnt4, flush_cnt4;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [31:0] m_instr = '0;
   logic [31:0] m_pc4 = '0;
   logic        m_valid = 1'b0;
   int          m_stall = 0;
   int          m_flush = 0;
   int          m_stall4 = 0;

   always #5 clk = ~clk;

   if_id_stage #(.DATA_W(32), .CNT_W(16), .NOP(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .order(order), .fa_out(fa_out), .redirect(redirect),
      .id_ex_memrd(id_ex_memrd), .id_ex_rt(id_ex_rt),
      .id_instr(id_instr), .id_pc4(id_pc4), .id_valid(id_valid), .hazard(hazard),
      .id_ex_bubble(id_ex_bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   if_id_stage #(.DATA_W(32), .CNT_W(4), .NOP(32'h0000_0000)) dut4 (
      .clk(clk), .rst(rst), .order(order), .fa_out(fa_out), .redirect(redirect),
      .id_ex_memrd(id_ex_memrd), .id_ex_rt(id_ex_rt),
      .id_instr(id_instr4), .id_pc4(id_pc44), .id_valid(id_valid4), .hazard(hazard4),
      .id_ex_bubble(id_ex_bubble4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
   );

   // Load-use rule: the load's destination is read by the decoding instruction.
   function automatic bit model_hazard(logic [31:0] instr, logic valid, logic memrd, logic [4:0] ldr);
      int op, rs, rt;
      bit reads_rt;
      op = int'(instr >> 26);
      rs = int'((instr >> 21) & 32'h1F);
      rt = int'((instr >> 16) & 32'h1F);
      reads_rt = (op == 0) || (op == 4) || (op == 5) || (op == 'h2B);
      if (!valid || !memrd || ldr == 0) return 1'b0;
      return (int'(ldr) == rs) || (reads_rt && int'(ldr) == rt);
   endfunction

   // Advance the model with the inputs currently applied, then cross one clock edge.
   task automatic tick();
      bit h;
      h = model_hazard(m_instr, m_valid, id_ex_memrd, id_ex_rt);
      if (rst) begin
         m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
         m_stall = 0; m_flush = 0; m_stall4 = 0;
      end else if (redirect) begin
         m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
         m_flush = (m_flush + 1 > 65535) ? 65535 : m_flush + 1;
      end else if (h) begin
         m_stall  = (m_stall + 1 > 65535) ? 65535 : m_stall + 1;
         m_stall4 = (m_stall4 + 1 > 15) ? 15 : m_stall4 + 1;
      end else begin
         m_instr = order; m_pc4 = fa_out; m_valid = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic load_instr(logic [31:0] ins, logic [31:0] pc4);
      redirect = 1'b0; id_ex_memrd = 1'b0; id_ex_rt = '0;
      order = ins; fa_out = pc4;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; order = 32'h8C08_0004; fa_out = 32'h0000_0004;
      tick(); tick();
      rst = 1'b0;
      #1;
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", id_valid); end
      checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 00000000", id_instr); end
      checks++; if (id_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h exp 00000000", id_pc4); end
      checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
      checks++; if (hazard !== 1'b0 || id_ex_bubble !== 1'b0) begin errors++; $display("FAIL reset_hazard got %0b/%0b exp 0/0", hazard, id_ex_bubble); end
      tick();
      checks++; if (id_instr !== 32'h8C08_0004) begin errors++; $display("FAIL first_load_instr got %h exp 8c080004", id_instr); end
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL first_load_valid got %0b exp 1", id_valid); end
      checks++; if (id_pc4 !== 32'h0000_0004) begin errors++; $display("FAIL first_load_pc4 got %h exp 00000004", id_pc4); end
   endtask

   task automatic test_load_use();
      logic [15:0] s0;
      load_instr(32'h0109_5020, 32'h0000_0104);
      order = 32'hDEAD_BEEF; fa_out = 32'h0000_0108;
      id_ex_memrd = 1'b1; id_ex_rt = 5'd8;
      #1;
      checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL lu_hazard_rs got %0b exp 1", hazard); end
      checks++; if (id_ex_bubble !== 1'b1) begin errors++; $display("FAIL lu_bubble got %0b exp 1", id_ex_bubble); end
      s0 = stall_cnt;
      tick();
      checks++; if (id_instr !== 32'h0109_5020 || id_pc4 !== 32'h0000_0104) begin errors++; $display("FAIL lu_hold got %h/%h exp 01095020/00000104", id_instr, id_pc4); end
      checks++; if (stall_cnt !== s0 + 16'd1) begin errors++; $display("FAIL lu_stall_cnt got %0d exp %0d", stall_cnt, s0 + 16'd1); end
      id_ex_rt = 5'd9;
      #1;
      checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL lu_hazard_rt got %0b exp 1", hazard); end
      id_ex_memrd = 1'b0;
      #1;
      checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL lu_release got %0b exp 0", hazard); end
      tick();
      checks++; if (id_instr !== 32'hDEAD_BEEF || id_pc4 !== 32'h0000_0108) begin errors++; $display("FAIL lu_advance got %h/%h exp deadbeef/00000108", id_instr, id_pc4); end
   endtask

   task automatic test_no_hazard();
      load_instr(32'h0109_5020, 32'h0000_0200);
      id_ex_memrd = 1'b1; id_ex_rt = 5'd0;
      #1;
      checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL nh_rt_zero got %0b exp 0", hazard); end
      id_ex_rt = 5'd11;
      #1;
      checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL nh_rt_11 got %0b exp 0", hazard); end
      load_instr(32'h8D28_0000, 32'h0000_0204);
      id_ex_memrd = 1'b1; id_ex_rt = 5'd8;
      #1;
      checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL nh_lw_rt got %0b exp 0", hazard); end
      id_ex_rt = 5'd9;
      #1;
      checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL nh_lw_rs got %0b exp 1", hazard); end
      id_ex_memrd = 1'b0;
   endtask

   task automatic test_hazard_redirect();
      logic [15:0] s0, f0;
      load_instr(32'h0109_5020, 32'h0000_0300);
      id_ex_memrd = 1'b1; id_ex_rt = 5'd8; redirect = 1'b1;
      #1;
      checks++; if (hazard !== 1'b1 || id_ex_bubble !== 1'b0) begin errors++; $display("FAIL hr_comb got %0b/%0b exp 1/0", hazard, id_ex_bubble); end
      s0 = stall_cnt; f0 = flush_cnt;
      tick();
      redirect = 1'b0;
      #1;
      checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc4 !== 32'h0) begin errors++; $display("FAIL hr_squash got %0b/%h/%h exp 0/0/0", id_valid, id_instr, id_pc4); end
      checks++; if (id_ex_bubble !== 1'b0 || hazard !== 1'b0) begin errors++; $display("FAIL hr_bubble got %0b/%0b exp 0/0", id_ex_bubble, hazard); end
      checks++; if (flush_cnt !== f0 + 16'd1) begin errors++; $display("FAIL hr_flush_cnt got %0d exp %0d", flush_cnt, f0 + 16'd1); end
      checks++; if (stall_cnt !== s0) begin errors++; $display("FAIL hr_stall_cnt got %0d exp %0d", stall_cnt, s0); end
      id_ex_memrd = 1'b0;
   endtask

   task automatic test_saturation();
      rst = 1'b1; tick(); rst = 1'b0;
      load_instr(32'h0109_5020, 32'h0000_0400);
      id_ex_memrd = 1'b1; id_ex_rt = 5'd8;
      for (int i = 0; i < 20; i++) tick();
      checks++; if (stall_cnt4 !== 4'd15) begin errors++; $display("FAIL sat_cnt4 got %0d exp 15", stall_cnt4); end
      checks++; if (stall_cnt !== 16'd20) begin errors++; $display("FAIL sat_cnt16 got %0d exp 20", stall_cnt); end
      rst = 1'b1; tick(); rst = 1'b0;
      #1;
      checks++; if (stall_cnt4 !== 4'd0 || hazard !== 1'b0) begin errors++; $display("FAIL sat_reset got %0d/%0b exp 0/0", stall_cnt4, hazard); end
      id_ex_memrd = 1'b0;
   endtask

   task automatic test_random();
      logic [31:0] ins;
      int ops[5] = '{'h00, 'h04, 'h05, 'h2B, 'h23};
      for (int n = 0; n < 600; n++) begin
         ins = $urandom;
         ins[31:26] = 6'(ops[$urandom_range(0, 4)]);
         ins[25:21] = 5'($urandom_range(0, 7));
         ins[20:16] = 5'($urandom_range(0, 7));
         order = ins;
         fa_out = $urandom;
         redirect = ($urandom_range(0, 7) == 0);
         id_ex_memrd = ($urandom_range(0, 2) != 0);
         id_ex_rt = 5'($urandom_range(0, 7));
         rst = ($urandom_range(0, 99) == 0);
         #1;
         checks++; if (hazard !== model_hazard(m_instr, m_valid, id_ex_memrd, id_ex_rt)) begin errors++; $display("FAIL rnd_hazard cyc %0d got %0b exp %0b", n, hazard, model_hazard(m_instr, m_valid, id_ex_memrd, id_ex_rt)); end
         checks++; if (id_ex_bubble !== (model_hazard(m_instr, m_valid, id_ex_memrd, id_ex_rt) && !redirect)) begin errors++; $display("FAIL rnd_bubble cyc %0d got %0b", n, id_ex_bubble); end
         checks++; if (!id_valid && hazard) begin errors++; $display("FAIL rnd_hazard_invalid cyc %0d got 1 exp 0", n); end
         tick();
         checks++; if (id_instr !== m_instr || id_pc4 !== m_pc4 || id_valid !== m_valid) begin errors++; $display("FAIL rnd_id cyc %0d got %h/%h/%0b exp %h/%h/%0b", n, id_instr, id_pc4, id_valid, m_instr, m_pc4, m_valid); end
         checks++; if (int'(stall_cnt) != m_stall || int'(flush_cnt) != m_flush || int'(stall_cnt4) != m_stall4) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d/%0d/%0d exp %0d/%0d/%0d", n, stall_cnt, flush_cnt, stall_cnt4, m_stall, m_flush, m_stall4); end
      end
      rst = 1'b0; redirect = 1'b0; id_ex_memrd = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_hazard();
      test_hazard_redirect();
      test_saturation();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
